// File: rtl/exec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_seq_pkg
// Description : Shared state encoding, default parameters and width helper
//               for the exec_sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam int c_def_tick_div = 25000000;
    localparam int c_def_mem_lat  = 2;
    localparam int c_def_max_exec = 64;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running modulo-TICK_DIV counter with a one-cycle tick
//               on the terminal count; held at zero while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider
    import exec_seq_pkg::*;
#(
    parameter int TICK_DIV = c_def_tick_div
) (
    input  logic CLOCK_50M,
    input  logic Resetn,
    input  logic en,
    output logic tick
);

    localparam int c_w = f_cnt_w(TICK_DIV);
    localparam logic [c_w-1:0] c_last = c_w'(TICK_DIV - 1);

    logic [c_w-1:0] r_cnt;
    logic           w_last;

    assign w_last = (r_cnt == c_last);

    always_ff @(posedge CLOCK_50M or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (!en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_w'(1);
        end
    end

    assign tick = en && w_last;

endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Drives fetch / settle / execute clock-enable pulses for the
//               processor datapath, in single-step or free-run mode, with an
//               execute watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int TICK_DIV = c_def_tick_div,
    parameter int MEM_LAT  = c_def_mem_lat,
    parameter int MAX_EXEC = c_def_max_exec,
    parameter int CNT_W    = 16
) (
    input  logic             CLOCK_50M,
    input  logic             Resetn,
    input  logic             auto_mode,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             clr_fault,
    input  logic             done,
    output logic             mem_en,
    output logic             proc_en,
    output logic             run,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int c_settle_w = f_cnt_w(MEM_LAT);
    localparam int c_exec_w   = f_cnt_w(MAX_EXEC);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic [c_exec_w-1:0]   r_exec_cnt;
    logic [CNT_W-1:0]      r_instr_cnt;
    logic                  w_tick;
    logic                  w_go;
    logic                  w_settle_last;
    logic                  w_exec_last;
    logic                  w_retire;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .CLOCK_50M (CLOCK_50M),
        .Resetn    (Resetn),
        .en        (auto_mode),
        .tick      (w_tick)
    );

    // halt_req only gates the auto-run tick; a manual step always proceeds.
    assign w_go          = auto_mode ? (w_tick && !halt_req) : step_req;
    assign w_settle_last = (r_settle_cnt == c_settle_w'(MEM_LAT - 1));
    assign w_exec_last   = (r_exec_cnt == c_exec_w'(MAX_EXEC - 1));

    always_ff @(posedge CLOCK_50M or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_go) w_state_nxt = ST_FETCH;
            ST_FETCH:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_settle_last) w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                // done takes priority over the watchdog limit in the same cycle
                if (done) begin
                    w_state_nxt = ST_IDLE;
                    w_retire    = 1'b1;
                end else if (w_exec_last) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_FAULT:  if (clr_fault) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50M or negedge Resetn) begin
        if (!Resetn) begin
            r_settle_cnt <= '0;
            r_exec_cnt   <= '0;
            r_instr_cnt  <= '0;
        end else begin
            if (r_state == ST_FETCH) begin
                r_settle_cnt <= '0;
            end else if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + c_settle_w'(1);
            end
            if (r_state == ST_SETTLE) begin
                r_exec_cnt <= '0;
            end else if (r_state == ST_EXEC && !done && !w_exec_last) begin
                r_exec_cnt <= r_exec_cnt + c_exec_w'(1);
            end
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_en    = (r_state == ST_FETCH);
    assign run       = (r_state == ST_EXEC);
    assign proc_en   = (r_state == ST_EXEC);
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_SETTLE) || (r_state == ST_EXEC);
    assign fault     = (r_state == ST_FAULT);
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Directed scoreboard bench for exec_sequencer; expected fetch,
//               run, retire and fault events are queued with their cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

    localparam int TICK_DIV = 4;
    localparam int MEM_LAT  = 1;
    localparam int MAX_EXEC = 8;
    localparam int CNT_W    = 16;

    localparam int EV_FETCH  = 0;
    localparam int EV_RUN    = 1;
    localparam int EV_RETIRE = 2;
    localparam int EV_FAULT  = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic             clk       = 1'b0;
    logic             Resetn    = 1'b0;
    logic             auto_mode = 1'b0;
    logic             step_req  = 1'b0;
    logic             halt_req  = 1'b0;
    logic             clr_fault = 1'b0;
    logic             done      = 1'b0;
    logic             mem_en;
    logic             proc_en;
    logic             run;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] instr_cnt;

    ev_t              q[$];
    int               cyc        = 0;
    int               n_checks   = 0;
    int               n_errors   = 0;
    int               exp_cnt    = 0;
    int               done_dly   = 0;
    int               run_cycles = 0;
    logic             prev_run   = 1'b0;
    logic             prev_fault = 1'b0;
    logic [CNT_W-1:0] prev_cnt   = '0;

    exec_sequencer #(
        .TICK_DIV (TICK_DIV),
        .MEM_LAT  (MEM_LAT),
        .MAX_EXEC (MAX_EXEC),
        .CNT_W    (CNT_W)
    ) dut (
        .CLOCK_50M (clk),
        .Resetn    (Resetn),
        .auto_mode (auto_mode),
        .step_req  (step_req),
        .halt_req  (halt_req),
        .clr_fault (clr_fault),
        .done      (done),
        .mem_en    (mem_en),
        .proc_en   (proc_en),
        .run       (run),
        .busy      (busy),
        .fault     (fault),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Processor model: raise done on the (done_dly+1)-th consecutive run cycle.
    always @(negedge clk) begin
        if (run) run_cycles = run_cycles + 1;
        else     run_cycles = 0;
        done = run && (run_cycles == done_dly + 1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        q.push_back(e);
    endtask

    // Instruction launched by go in cycle t, done asserted d cycles after run rises.
    task automatic expect_instr(input int t, input int d);
        push(EV_FETCH, t + 1, 0);
        push(EV_RUN, t + 2 + MEM_LAT, 0);
        exp_cnt++;
        push(EV_RETIRE, t + 3 + MEM_LAT + d, exp_cnt);
    endtask

    task automatic check_ev(input int kind, input int v);
        ev_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_errors++;
            $display("FAIL event: unexpected kind %0d val %0d at cycle %0d", kind, v, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != v) begin
                n_errors++;
                $display("FAIL event: got kind %0d cycle %0d val %0d, expected kind %0d cycle %0d val %0d",
                         kind, cyc, v, e.kind, e.cyc, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (Resetn) begin
            if (mem_en)                    check_ev(EV_FETCH, 0);
            if (run && !prev_run)          check_ev(EV_RUN, 0);
            if (instr_cnt != prev_cnt)     check_ev(EV_RETIRE, int'(instr_cnt));
            if (fault && !prev_fault)      check_ev(EV_FAULT, 0);
        end
        prev_run   = run;
        prev_fault = fault;
        prev_cnt   = instr_cnt;
    end

    task automatic at_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic pulse_step(input int t);
        at_cyc(t);
        step_req = 1'b1;
        at_cyc(t + 1);
        step_req = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset mem_en", int'(mem_en), 0);
        chk("reset run", int'(run), 0);
        chk("reset proc_en", int'(proc_en), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset fault", int'(fault), 0);
        chk("reset instr_cnt", int'(instr_cnt), 0);
        at_cyc(2);
        #2 Resetn = 1'b1;

        // Single step: go at 10, done at 15
        done_dly = 2;
        expect_instr(10, 2);
        pulse_step(10);
        at_cyc(13);
        chk("step run rise", int'(run), 1);
        chk("step proc_en", int'(proc_en), 1);
        at_cyc(16);
        chk("step run fall", int'(run), 0);
        chk("step busy low", int'(busy), 0);
        chk("step instr_cnt", int'(instr_cnt), 1);

        // Auto-run back to back: go every TICK_DIV cycles
        done_dly = 0;
        for (int k = 0; k < 5; k++) expect_instr(23 + 4 * k, 0);
        at_cyc(20);
        auto_mode = 1'b1;
        at_cyc(40);
        auto_mode = 1'b0;
        at_cyc(44);
        chk("auto instr_cnt", int'(instr_cnt), 6);
        chk("auto busy", int'(busy), 0);

        // Auto-run with tick at 57 landing in EXEC and dropped
        expect_instr(53, 1);
        expect_instr(61, 1);
        at_cyc(50);
        done_dly  = 1;
        auto_mode = 1'b1;
        at_cyc(63);
        auto_mode = 1'b0;
        at_cyc(67);
        chk("drop tick instr_cnt", int'(instr_cnt), 8);

        // Halt raised mid-EXEC; ticks 81 and 85 blocked, 89 resumes
        expect_instr(73, 2);
        expect_instr(89, 2);
        at_cyc(70);
        done_dly  = 2;
        auto_mode = 1'b1;
        at_cyc(77);
        halt_req = 1'b1;
        at_cyc(86);
        chk("halt busy", int'(busy), 0);
        chk("halt instr_cnt", int'(instr_cnt), 9);
        halt_req = 1'b0;
        at_cyc(91);
        auto_mode = 1'b0;
        at_cyc(96);
        chk("resume instr_cnt", int'(instr_cnt), 10);

        // Watchdog: done never comes
        done_dly = 99;
        push(EV_FETCH, 101, 0);
        push(EV_RUN, 103, 0);
        push(EV_FAULT, 103 + MAX_EXEC, 0);
        pulse_step(100);
        at_cyc(111);
        chk("wdog fault", int'(fault), 1);
        chk("wdog run", int'(run), 0);
        chk("wdog proc_en", int'(proc_en), 0);
        chk("wdog busy", int'(busy), 0);
        pulse_step(114);
        at_cyc(116);
        chk("wdog fault held", int'(fault), 1);
        at_cyc(118);
        clr_fault = 1'b1;
        at_cyc(119);
        clr_fault = 1'b0;
        chk("clr fault", int'(fault), 0);
        chk("clr busy", int'(busy), 0);
        chk("clr instr_cnt", int'(instr_cnt), 10);

        // Step during SETTLE dropped; done on the watchdog-limit cycle retires
        done_dly = 7;
        expect_instr(130, 7);
        pulse_step(130);
        pulse_step(132);
        at_cyc(141);
        chk("tie fault", int'(fault), 0);
        chk("tie instr_cnt", int'(instr_cnt), 11);
        at_cyc(142);
        chk("tie busy", int'(busy), 0);

        // Asynchronous reset in the middle of EXEC
        done_dly = 99;
        push(EV_FETCH, 151, 0);
        push(EV_RUN, 153, 0);
        pulse_step(150);
        at_cyc(155);
        #2 Resetn = 1'b0;
        #1;
        chk("areset run", int'(run), 0);
        chk("areset proc_en", int'(proc_en), 0);
        chk("areset busy", int'(busy), 0);
        chk("areset fault", int'(fault), 0);
        chk("areset instr_cnt", int'(instr_cnt), 0);
        exp_cnt = 0;
        at_cyc(156);
        #2 Resetn = 1'b1;
        at_cyc(158);
        chk("post reset busy", int'(busy), 0);
        done_dly = 0;
        expect_instr(160, 0);
        pulse_step(160);
        at_cyc(166);
        chk("post reset instr_cnt", int'(instr_cnt), 1);

        at_cyc(170);
        chk("events outstanding", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish by cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
